// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back L2 cache between a block-granular L1
// and main memory. Write-back with per-line dirty bits, true-LRU replacement,
// victim writeback before refill, write-allocate without refill, and
// saturating hit/miss/writeback counters. All outputs are registered.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   l1_cache_addr            word address of the L1 request
//   l1_cache_data_in         full block for writes
//   l1_cache_read/write      request, held by the L1 until l1_cache_ready
//   l1_block_data_out        read data (valid with l1_block_valid)
//   l1_block_valid           read data valid (reads only)
//   l1_cache_ready           one-cycle completion pulse
//   l1_cache_hit             completed request hit (valid with ready)
//   mem_addr                 block-aligned memory address
//   mem_data_out             writeback data
//   mem_read / mem_write     refill / writeback request, held until mem_ready
//   mem_data_block           refill data, valid with mem_ready
//   mem_ready                memory completion pulse
//   hit_cnt/miss_cnt/wb_cnt  saturating performance counters
//
// Handshake: a request (read/write) is a level held by its source until the
// matching one-cycle completion pulse (l1_cache_ready / mem_ready) is seen; the
// pulse completes exactly one transfer, and a completion pulse that arrives
// when no transfer is pending is ignored.
module l2_cache_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             l1_cache_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_cache_data_in,
  input  logic                              l1_cache_read,
  input  logic                              l1_cache_write,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l1_block_data_out,
  output logic                              l1_block_valid,
  output logic                              l1_cache_ready,
  output logic                              l1_cache_hit,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_out,
  output logic                              mem_read,
  output logic                              mem_write,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_block,
  input  logic                              mem_ready,
  output logic [CNT_WIDTH-1:0]              hit_cnt,
  output logic [CNT_WIDTH-1:0]              miss_cnt,
  output logic [CNT_WIDTH-1:0]              wb_cnt
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int BLK_W = BLOCK_WORDS * DATA_WIDTH;
  localparam logic [WAY_W-1:0]     AGE_OLD = WAY_W'(NUM_WAYS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  is_write_q, is_write_d;
  logic [BLK_W-1:0]      wdata_q, wdata_d;
  logic [WAY_W-1:0]      victim_q, victim_d;

  // Per-line state (reset) and storage arrays (no reset)
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [WAY_W-1:0]    age_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    age_d [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    data_mem [NUM_SETS][NUM_WAYS];

  // Counters
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  // Registered outputs
  logic [BLK_W-1:0]      blk_data_q, blk_data_d;
  logic                  blk_valid_q, blk_valid_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]      mem_data_q, mem_data_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  // Lookup results
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way, lru_way, victim_sel, wb_way;
  logic             victim_dirty;

  // Array write port and LRU update controls
  logic             arr_we;
  logic [WAY_W-1:0] arr_way;
  logic [BLK_W-1:0] arr_data;
  logic             acc_en, acc_fill;
  logic [WAY_W-1:0] acc_way, old_age;

  // Word offset within the block does not affect block-granular accesses.
  logic unused_offset;
  assign unused_offset = ^addr_q[OFF_W-1:0];

  assign req_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];

  // Tag compare and victim choice. The descending loop leaves the lowest
  // matching / invalid way as the final assignment.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[req_idx][w] == AGE_OLD) lru_way = WAY_W'(w);
    end
    victim_sel   = inv_found ? inv_way : lru_way;
    victim_dirty = valid_q[req_idx][victim_sel] & dirty_q[req_idx][victim_sel];
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (l1_cache_read || l1_cache_write) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit)               state_d = S_RESP;
        else if (victim_dirty) state_d = S_WRITEBACK;
        else if (!is_write_q)  state_d = S_REFILL;
        else                   state_d = S_RESP;
      end
      S_WRITEBACK: if (mem_ready) state_d = is_write_q ? S_RESP : S_REFILL;
      S_REFILL:    if (mem_ready) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, line state, counters, LRU
  always_comb begin
    addr_d     = addr_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    age_d      = age_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    arr_we     = 1'b0;
    arr_way    = '0;
    arr_data   = '0;
    acc_en     = 1'b0;
    acc_fill   = 1'b0;
    acc_way    = '0;
    old_age    = '0;
    case (state_q)
      S_IDLE: begin
        if (l1_cache_read || l1_cache_write) begin
          addr_d     = l1_cache_addr;
          is_write_d = l1_cache_write & ~l1_cache_read;  // read wins a tie
          wdata_d    = l1_cache_data_in;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + 1'b1;
          acc_en  = 1'b1;
          acc_way = hit_way;
          if (is_write_q) begin
            arr_we   = 1'b1;
            arr_way  = hit_way;
            arr_data = wdata_q;
            dirty_d[req_idx][hit_way] = 1'b1;
          end
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + 1'b1;
          victim_d = victim_sel;
          // Clean-victim write miss: allocate without fetching the old block.
          if (!victim_dirty && is_write_q) begin
            arr_we   = 1'b1;
            arr_way  = victim_sel;
            arr_data = wdata_q;
            valid_d[req_idx][victim_sel] = 1'b1;
            dirty_d[req_idx][victim_sel] = 1'b1;
            acc_en   = 1'b1;
            acc_fill = 1'b1;
            acc_way  = victim_sel;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          if (wb_cnt_q != CNT_MAX) wb_cnt_d = wb_cnt_q + 1'b1;
          valid_d[req_idx][victim_q] = 1'b0;
          dirty_d[req_idx][victim_q] = 1'b0;
          if (is_write_q) begin
            arr_we   = 1'b1;
            arr_way  = victim_q;
            arr_data = wdata_q;
            valid_d[req_idx][victim_q] = 1'b1;
            dirty_d[req_idx][victim_q] = 1'b1;
            acc_en   = 1'b1;
            acc_fill = 1'b1;
            acc_way  = victim_q;
          end
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          arr_we   = 1'b1;
          arr_way  = victim_q;
          arr_data = mem_data_block;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
          acc_en   = 1'b1;
          acc_fill = 1'b1;
          acc_way  = victim_q;
        end
      end
      default: ;
    endcase
    // True LRU: a freshly filled way is treated as oldest before the update,
    // so every other valid way ages by one.
    if (acc_en) begin
      old_age = acc_fill ? AGE_OLD : age_q[req_idx][acc_way];
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == acc_way)
          age_d[req_idx][w] = '0;
        else if (valid_q[req_idx][w] && (age_q[req_idx][w] < old_age))
          age_d[req_idx][w] = age_q[req_idx][w] + 1'b1;
      end
    end
  end

  // FSM outputs, decoded from the next state so they are registered in step
  // with the state they belong to.
  always_comb begin
    wb_way      = (state_q == S_LOOKUP) ? victim_sel : victim_q;
    ready_d     = (state_d == S_RESP);
    blk_valid_d = ready_d & ~is_write_q;
    blk_data_d  = '0;
    if (blk_valid_d)
      blk_data_d = (state_q == S_REFILL) ? mem_data_block : data_mem[req_idx][hit_way];
    hit_d       = ready_d & (state_q == S_LOOKUP) & hit;
    mem_write_d = (state_d == S_WRITEBACK);
    mem_read_d  = (state_d == S_REFILL);
    mem_addr_d  = '0;
    mem_data_d  = '0;
    if (mem_write_d) begin
      mem_addr_d = {tag_mem[req_idx][wb_way], req_idx, {OFF_W{1'b0}}};
      mem_data_d = data_mem[req_idx][wb_way];
    end else if (mem_read_d) begin
      mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
    end
  end

  // Control registers and line state
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      wdata_q     <= '0;
      victim_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      hit_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      addr_q      <= addr_d;
      is_write_q  <= is_write_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      ready_q     <= ready_d;
      hit_q       <= hit_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      age_q       <= age_d;
    end
  end

  // Tag/data storage; contents are only meaningful where valid is set.
  always_ff @(posedge clk) begin
    if (arr_we && !rst) begin
      data_mem[req_idx][arr_way] <= arr_data;
      tag_mem[req_idx][arr_way]  <= req_tag;
    end
  end

  assign l1_block_data_out = blk_data_q;
  assign l1_block_valid    = blk_valid_q;
  assign l1_cache_ready    = ready_q;
  assign l1_cache_hit      = hit_q;
  assign mem_addr          = mem_addr_q;
  assign mem_data_out      = mem_data_q;
  assign mem_read          = mem_read_q;
  assign mem_write         = mem_write_q;
  assign hit_cnt           = hit_cnt_q;
  assign miss_cnt          = miss_cnt_q;
  assign wb_cnt            = wb_cnt_q;
endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
- Parametrised set-associative L2 cache, the next generation of the team's L2 block.
- Sits between the L1 (block-granular read/write requests) and main memory (block transfers).
- Adds over the previous L2: write-back with per-line dirty bits, true-LRU replacement, victim writeback before refill, write-allocate without refill, and saturating hit/miss/writeback counters.
- All outputs are registered.

Parameters:
- DATA_WIDTH, 32, bits per word
- ADDR_WIDTH, 32, word-address width
- BLOCK_WORDS, 16, words per block (power of 2)
- NUM_SETS, 16, number of sets (power of 2)
- NUM_WAYS, 4, associativity (power of 2, at least 2)
- CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- l1_cache_addr  in  ADDR_WIDTH  word address of the request
- l1_cache_data_in  in  BLOCK_WORDS*DATA_WIDTH  full block to write
- l1_cache_read  in  1  read request; held until l1_cache_ready
- l1_cache_write  in  1  full-block write request; held until l1_cache_ready
- l1_block_data_out  out  BLOCK_WORDS*DATA_WIDTH  read data
- l1_block_valid  out  1  l1_block_data_out is valid (reads only)
- l1_cache_ready  out  1  one-cycle completion pulse
- l1_cache_hit  out  1  completed request hit; valid with ready
- mem_addr  out  ADDR_WIDTH  block-aligned address (offset bits zero)
- mem_data_out  out  BLOCK_WORDS*DATA_WIDTH  writeback data
- mem_read  out  1  refill request; held until mem_ready
- mem_write  out  1  writeback request; held until mem_ready
- mem_data_block  in  BLOCK_WORDS*DATA_WIDTH  refill data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- hit_cnt, miss_cnt, wb_cnt  out  CNT_WIDTH each  saturating counters

Behaviour:
- Address split: offset = low log2(BLOCK_WORDS) bits; index = next log2(NUM_SETS) bits; tag = remaining bits.
- Reset (rst high at an edge), from any state:
  - state goes to IDLE.
  - All valid, dirty and LRU state clears.
  - Every output is 0, including the counters.
  - Any in-flight mem_read/mem_write drops on the next cycle. A later mem_ready is ignored.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESP.
- IDLE: if read or write is high, latch addr, op and data_in, then go to LOOKUP. Read and write both high: treated as a read.
- LOOKUP:
  - Hit: access the way. A write stores data_in and sets dirty. Go to RESP with hit=1.
  - Miss: select a victim.
    - Victim dirty: go to WRITEBACK.
    - Victim clean, op is read: go to REFILL.
    - Victim clean, op is write: install data_in (valid=1, dirty=1), go to RESP with hit=0.
- Victim selection: lowest-index invalid way; otherwise the way with LRU age NUM_WAYS-1.
- WRITEBACK:
  - mem_write=1, mem_addr = {victim tag, index, 0}, mem_data_out = victim block.
  - On mem_ready: clear the victim's valid and dirty bits and increment wb_cnt.
  - Then read goes to REFILL; write installs data_in dirty and goes to RESP.
- REFILL:
  - mem_read=1, mem_addr = {tag, index, 0}.
  - On mem_ready: install mem_data_block (valid=1, dirty=0) and go to RESP.
- RESP:
  - Exactly one cycle with l1_cache_ready=1.
  - Reads: l1_block_valid=1 and l1_block_data_out = block. Writes: l1_block_valid=0.
  - Go to IDLE. Requests are not sampled while in RESP.
- mem_ready is sampled only in WRITEBACK and REFILL; elsewhere it is ignored. mem_read and mem_write are never high together.
- Latency, counted from the IDLE sampling edge:
  - Hit: ready is high 2 cycles later.
  - Miss: ready is high 1 cycle after the final mem_ready.
- LRU: per-set age of log2(NUM_WAYS) bits per way. On hit or install, the accessed way's age becomes 0 and every valid way younger than its old age increments. A newly filled way counts as oldest-age before the update.
- Counters: hit_cnt and miss_cnt increment in LOOKUP. All three counters saturate at all-ones.
- Outputs not named above are 0 in each state.

Test Plan:
- Read miss then hit: after reset, read 0x40. Expect mem_read=1 with mem_addr=0x40. Memory returns block A after 3 cycles. Expect ready once with hit=0 and data=A. Read 0x40 again: ready 2 cycles later, hit=1, data=A, no mem activity. Expect hit_cnt=1, miss_cnt=1.
- LRU eviction: read 0x000, 0x100, 0x200, 0x300 (set 0 full), then re-read 0x000. Read 0x400: the refill replaces the 0x100 line with no mem_write. A later read of 0x100 misses; a read of 0x000 hits.
- Dirty writeback: write block W to 0x200 (hit). Force eviction of 0x200. Expect mem_write with mem_addr=0x200 and data=W before any mem_read. Expect wb_cnt=1.
- Write-allocate miss: write block X to 0x500 with a clean victim. Expect no mem_read; ready with hit=0. A read of 0x500 then hits and returns X.
- Reset mid-refill: assert rst while in REFILL. Next cycle: mem_read=0, all outputs 0. A mem_ready pulse afterwards causes no install. Re-reading the address misses.
- Simultaneous read and write to 0x40 (hit): serviced as a read. Expect data returned and the line not dirtied; its eviction causes no mem_write.
